// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction, host-load, debug and ALU-side signals of alu_sequencer
interface alu_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_opcode;
  logic        alu_cin;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done;

  modport slave (
    input  instr_valid, instr, ld_en, ld_addr, ld_data, dbg_addr, alu_c, alu_flags,
    output instr_ready, dbg_data, alu_a, alu_b, alu_opcode, alu_cin, psr, done
  );

  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data, dbg_addr, alu_c, alu_flags,
    input  instr_ready, dbg_data, alu_a, alu_b, alu_opcode, alu_cin, psr, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - single-issue IDLE/READ/EXEC/WB sequencer with 16x16 register file and PSR
module alu_sequencer (
  input  logic           i_clk,
  input  logic           i_reset_n,
  alu_sequencer_if.slave io_seq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_regs [16];
  logic [15:0] r_ir;
  logic [15:0] r_res;
  logic [4:0]  r_flg;
  logic [4:0]  r_psr;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [15:0] r_alu_opcode;
  logic        r_alu_cin;
  logic        w_idle;
  logic        w_accept;
  logic        w_ld;
  logic        w_legal;
  logic        w_wb_en;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & io_seq.instr_valid;
  assign w_ld     = w_idle & io_seq.ld_en;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Anything not in the decode table is a NOP: no write-back and the PSR is left alone.
  always_comb begin
    w_legal = 1'b0;
    w_wb_en = 1'b0;
    case (r_ir[15:12])
      4'h0: begin
        case (r_ir[7:4])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hD: begin
            w_legal = 1'b1;
            w_wb_en = 1'b1;
          end
          4'hB, 4'hF: w_legal = 1'b1;
          default: ;
        endcase
      end
      4'h5, 4'h6, 4'h7: begin
        w_legal = 1'b1;
        w_wb_en = 1'b1;
      end
      4'h8: begin
        case (r_ir[7:4])
          4'h0, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB: begin
            w_legal = 1'b1;
            w_wb_en = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // A host load shares the accept edge, so READ already sees the loaded value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (w_ld) begin
      r_regs[io_seq.ld_addr] <= io_seq.ld_data;
    end else if ((r_state == S_WB) && w_wb_en) begin
      r_regs[r_ir[11:8]] <= r_res;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ir         <= '0;
      r_res        <= '0;
      r_flg        <= '0;
      r_psr        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_alu_cin    <= 1'b0;
    end else begin
      if (w_accept) r_ir <= io_seq.instr;
      if (r_state == S_READ) begin
        r_alu_a      <= r_regs[r_ir[11:8]];
        r_alu_b      <= r_regs[r_ir[3:0]];
        r_alu_opcode <= r_ir;
        r_alu_cin    <= r_psr[3];
      end
      if (r_state == S_EXEC) begin
        r_res <= io_seq.alu_c;
        r_flg <= io_seq.alu_flags;
      end
      if ((r_state == S_WB) && w_legal) r_psr <= r_flg;
    end
  end

  assign io_seq.instr_ready = w_idle;
  assign io_seq.done        = (r_state == S_WB);
  assign io_seq.dbg_data    = r_regs[io_seq.dbg_addr];
  assign io_seq.alu_a       = r_alu_a;
  assign io_seq.alu_b       = r_alu_b;
  assign io_seq.alu_opcode  = r_alu_opcode;
  assign io_seq.alu_cin     = r_alu_cin;
  assign io_seq.psr         = r_psr;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed and randomized bench for alu_sequencer with an ALU and reference model
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .io_seq    (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;

  function automatic logic [17:0] add16(logic [15:0] a, logic [15:0] b, logic cin);
    logic [16:0] s;
    logic        ovf;
    s   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    ovf = (a[15] == b[15]) && (s[15] != a[15]);
    return {s[16], ovf, s[15:0]};
  endfunction

  // Stand-in ALU: {flags Z,C,O,N,L, result}
  function automatic logic [20:0] alu_model(logic [15:0] op, logic [15:0] a, logic [15:0] b, logic cin);
    logic [15:0] c;
    logic [4:0]  f;
    logic [17:0] r;
    logic [15:0] imm;
    logic        zauto;
    imm   = {{8{op[7]}}, op[7:0]};
    c     = '0;
    f     = '0;
    zauto = 1'b1;
    case (op[15:12])
      4'h0: begin
        case (op[7:4])
          4'h1: c = a & b;
          4'h2: c = a | b;
          4'h3: c = a ^ b;
          4'h4: c = ~b;
          4'h5, 4'h6: begin r = add16(a, b, 1'b0); c = r[15:0]; f[3] = r[17]; f[2] = r[16]; end
          4'h7: begin r = add16(a, b, cin); c = r[15:0]; f[3] = r[17]; f[2] = r[16]; end
          4'h8: c = b;
          4'h9: begin c = a - b; f[3] = (a < b); end
          4'hD: c = 16'(a * b);
          4'hB, 4'hF: begin
            c = a - b;
            zauto = 1'b0;
            f[4] = (a == b);
            f[1] = ($signed(a) < $signed(b));
            f[0] = (a < b);
          end
          default: begin c = a ^ b ^ 16'h5A5A; f = 5'b10101; zauto = 1'b0; end
        endcase
      end
      4'h5, 4'h6: begin r = add16(a, imm, 1'b0); c = r[15:0]; f[3] = r[17]; f[2] = r[16]; end
      4'h7: begin r = add16(a, imm, cin); c = r[15:0]; f[3] = r[17]; f[2] = r[16]; end
      4'h8: begin
        case (op[7:4])
          4'h0: c = a << b[3:0];
          4'h4: c = a >> b[3:0];
          4'h8: c = a << op[3:0];
          4'h9: c = a >> op[3:0];
          4'hA: c = $signed(a) >>> op[3:0];
          4'hB: c = (a << op[3:0]) | (a >> (5'd16 - {1'b0, op[3:0]}));
          default: begin c = ~a; f = 5'b01010; zauto = 1'b0; end
        endcase
      end
      default: begin c = a + b + 16'h1234; f = 5'b11111; zauto = 1'b0; end
    endcase
    if (zauto) f[4] = (c == 16'h0000);
    return {f, c};
  endfunction

  // {legal, wb_en}
  function automatic logic [1:0] ref_decode(logic [15:0] ins);
    logic [3:0] hi;
    logic [3:0] ext;
    hi  = ins[15:12];
    ext = ins[7:4];
    if (hi == 4'h0 && (ext inside {[4'h1:4'h9], 4'hD})) return 2'b11;
    if (hi == 4'h0 && (ext inside {4'hB, 4'hF}))        return 2'b10;
    if (hi inside {4'h5, 4'h6, 4'h7})                   return 2'b11;
    if (hi == 4'h8 && (ext inside {4'h0, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB})) return 2'b11;
    return 2'b00;
  endfunction

  assign {bus.alu_flags, bus.alu_c} = alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    bus.dbg_addr = addr;
    #1;
    chk(tag, 32'(bus.dbg_data), 32'(exp));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(bus.dbg_data), 32'(m_regs[i]));
    end
  endtask

  task automatic host_load(input logic [3:0] addr, input logic [15:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    @(negedge clk);
    bus.ld_en = 1'b0;
    m_regs[addr] = data;
  endtask

  // Entered and left on a negedge in IDLE.
  task automatic run(input logic [15:0] ins, input bit hold, input logic [15:0] nxt,
                     input bit ld_acc, input logic [3:0] la, input logic [15:0] ld, input bit ld_busy);
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ecin;
    logic [20:0] res;
    logic [1:0]  dec;
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.ld_en       = ld_acc;
    bus.ld_addr     = la;
    bus.ld_data     = ld;
    #1;
    chk("ready_idle", 32'(bus.instr_ready), 32'd1);
    if (ld_acc) m_regs[la] = ld;
    ea   = m_regs[ins[11:8]];
    eb   = m_regs[ins[3:0]];
    ecin = m_psr[3];
    res  = alu_model(ins, ea, eb, ecin);
    dec  = ref_decode(ins);
    @(negedge clk);
    bus.instr_valid = hold;
    bus.ld_en       = ld_busy;
    bus.ld_addr     = 4'($urandom);
    bus.ld_data     = 16'($urandom);
    chk("ready_read", 32'(bus.instr_ready), 32'd0);
    chk("done_read", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.ld_en = 1'b0;
    chk("ready_exec", 32'(bus.instr_ready), 32'd0);
    chk("alu_a", 32'(bus.alu_a), 32'(ea));
    chk("alu_b", 32'(bus.alu_b), 32'(eb));
    chk("alu_opcode", 32'(bus.alu_opcode), 32'(ins));
    chk("alu_cin", 32'(bus.alu_cin), 32'(ecin));
    chk("done_exec", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("done_wb", 32'(bus.done), 32'd1);
    chk("ready_wb", 32'(bus.instr_ready), 32'd0);
    bus.instr = nxt;
    if (dec[0]) m_regs[ins[11:8]] = res[15:0];
    if (dec[1]) m_psr = res[20:16];
    @(negedge clk);
    if (!hold) bus.instr_valid = 1'b0;
    chk("done_after", 32'(bus.done), 32'd0);
    chk("ready_after", 32'(bus.instr_ready), 32'd1);
    chk("psr", 32'(bus.psr), 32'(m_psr));
    check_regs($sformatf("regs_%h", ins));
  endtask

  initial begin
    logic [15:0] ins;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ld_en       = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.dbg_addr    = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_psr", 32'(bus.psr), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_opcode), 32'd0);
    chk("rst_alu_cin", 32'(bus.alu_cin), 32'd0);
    check_regs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    host_load(4'd1, 16'h0005);
    host_load(4'd2, 16'h0003);
    run(16'h0152, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    chk_reg("add_r1", 4'd1, 16'h0008);
    chk_reg("add_r2", 4'd2, 16'h0003);
    chk("add_psr", 32'(bus.psr), 32'h00);

    host_load(4'd1, 16'h7FFF);
    host_load(4'd2, 16'h0001);
    run(16'h0152, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    chk_reg("ovf_r1", 4'd1, 16'h8000);
    chk("ovf_psr", 32'(bus.psr), 32'h04);

    host_load(4'd1, 16'h0002);
    host_load(4'd2, 16'h0005);
    run(16'h01B2, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    chk_reg("cmp_r1", 4'd1, 16'h0002);
    chk("cmp_psr", 32'(bus.psr), 32'h03);

    host_load(4'd3, 16'hFFFF);
    host_load(4'd4, 16'h0001);
    run(16'h0354, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    chk_reg("carry_r3", 4'd3, 16'h0000);
    chk("carry_psr", 32'(bus.psr), 32'h18);
    host_load(4'd5, 16'h0000);
    host_load(4'd6, 16'h0000);
    run(16'h0576, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    chk_reg("addc_r5", 4'd5, 16'h0001);
    chk("addc_psr", 32'(bus.psr), 32'h00);

    // Same-register operands, and a host load landing on the accept edge.
    run(16'h0755, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    run(16'h0152, 0, 16'h0, 1, 4'd2, 16'h0010, 0);

    host_load(4'd1, 16'h0005);
    host_load(4'd2, 16'h0003);
    host_load(4'd3, 16'hFFFF);
    host_load(4'd4, 16'h0001);
    run(16'h0354, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    run(16'h0000, 1, 16'h0152, 0, 4'd0, 16'h0, 0);
    chk("nop_psr", 32'(bus.psr), 32'h18);
    chk_reg("nop_r1", 4'd1, 16'h0005);
    run(16'h0152, 0, 16'h0, 0, 4'd0, 16'h0, 0);
    chk_reg("bp_r1", 4'd1, 16'h0008);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: ins = {4'h0, 4'($urandom), 4'($urandom), 4'($urandom)};
        1: ins = {4'($urandom_range(5, 7)), 4'($urandom), 4'($urandom), 4'($urandom)};
        2: ins = {4'h8, 4'($urandom), 4'($urandom), 4'($urandom)};
        default: ins = 16'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) host_load(4'($urandom), 16'($urandom));
      run(ins, 0, 16'h0, bit'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
          bit'($urandom_range(0, 1)));
    end

    host_load(4'd1, 16'h0005);
    host_load(4'd2, 16'h0003);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h0152;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.dbg_addr = 4'd1;
    #1;
    chk("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_psr", 32'(bus.psr), 32'd0);
    chk("mid_rst_r1", 32'(bus.dbg_data), 32'd0);
    @(negedge clk);
    chk("mid_rst_done2", 32'(bus.done), 32'd0);
    chk("mid_rst_ready2", 32'(bus.instr_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
    @(negedge clk);
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_psr", 32'(bus.psr), 32'd0);
    check_regs("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
